// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Shared types and helpers for the phase sequencer slice.
//   - seqState_e : sequencer state encoding (IDLE, EXEC, WAIT, HALTED)
//   - PH_W       : phase-index width for the default five-phase build
//   - WAIT_W     : wait-counter width for the default MAX_WAIT of 3
//   - nextPhase  : next phase index after the current one, honouring a skip mask
// ---------------------------------------------------------------------------
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    WAIT   = 2'd2,
    HALTED = 2'd3
  } seqState_e;

  localparam int NUM_PHASES_DEF = 5;
  localparam int MAX_WAIT_DEF   = 3;
  localparam int PH_W           = $clog2(NUM_PHASES_DEF);
  localparam int WAIT_W         = $clog2(MAX_WAIT_DEF + 1);

  // Returns the first index above cur whose skip bit is clear. The last
  // phase always executes, so the search falls back to lastIdx. Index 0 is
  // never a candidate, which is why skip bit 0 has no effect.
  function automatic int nextPhase(input int cur, input int lastIdx,
                                   input logic [31:0] skipMask);
    int  result;
    int  cand;
    bit  found;
    result = lastIdx;
    found  = 1'b0;
    for (int i = 1; i < 32; i++) begin
      cand = cur + i;
      if (!found && (cand < lastIdx) && !skipMask[cand[4:0]]) begin
        result = cand;
        found  = 1'b1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/phase_sequencer_wait_counter.sv
// ---------------------------------------------------------------------------
// wait_counter
// Loadable down-counter that holds the memory wait-state budget.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   load_i       : load clip(load_val_i, MAX_WAIT) into the counter
//   dec_i        : decrement by one (stops at zero)
//   load_val_i   : requested number of extra cycles
//   zero_o       : counter is zero
//   last_o       : counter is one, i.e. this is the final wait cycle
// ---------------------------------------------------------------------------
module wait_counter #(
  parameter int MAX_WAIT = 3,
  parameter int WAIT_W   = $clog2(MAX_WAIT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              dec_i,
  input  logic [WAIT_W-1:0] load_val_i,
  output logic              zero_o,
  output logic              last_o
);

  logic [WAIT_W-1:0] count_q, count_d;
  logic [WAIT_W-1:0] clipVal;

  // Requests above MAX_WAIT saturate; the compare is done at 32 bits so it
  // stays meaningful whatever the port width is.
  always_comb begin
    clipVal = load_val_i;
    if (32'(load_val_i) > 32'(MAX_WAIT)) begin
      clipVal = WAIT_W'(MAX_WAIT);
    end
  end

  // Load has priority over decrement; decrement never wraps below zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = clipVal;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - WAIT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);
  assign last_o = (count_q == WAIT_W'(1));

endmodule

// File: rtl/phase_sequencer.sv
// ---------------------------------------------------------------------------
// phase_sequencer
// Generates one-hot phase strobes for the multi-cycle core, with memory
// wait-state stretching, free-run / single-step modes, sticky halt and an
// instruction counter.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   run          : level, free-run consecutive instructions
//   step         : one-cycle pulse, starts one instruction when idle
//   halt_req     : decoder HLT, only looked at in the final cycle
//   mem_wait     : extra cycles for WAIT_PHASE, sampled on its first cycle
//   skip         : per-phase skip mask (PHASE_SKIP_EN builds only)
//   phase        : one-hot active phase, zero when not executing
//   phase_idx    : index of active phase, zero when not executing
//   instr_done   : final cycle of the last phase
//   busy         : instruction in progress
//   halted       : sticky halt flag, cleared only by rst
//   instr_count  : completed-instruction count (wraps)
// Build option: define PHASE_SKIP_EN to honour the skip mask.
// ---------------------------------------------------------------------------
module phase_sequencer
  import seq_pkg::*;
#(
  parameter int NUM_PHASES = 5,
  parameter int WAIT_PHASE = 1,
  parameter int MAX_WAIT   = 3,
  parameter int CNT_W      = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            run,
  input  logic                            step,
  input  logic                            halt_req,
  input  logic [$clog2(MAX_WAIT+1)-1:0]   mem_wait,
  input  logic [NUM_PHASES-1:0]           skip,
  output logic [NUM_PHASES-1:0]           phase,
  output logic [$clog2(NUM_PHASES)-1:0]   phase_idx,
  output logic                            instr_done,
  output logic                            busy,
  output logic                            halted,
  output logic [CNT_W-1:0]                instr_count
);

  localparam int PHASE_W  = $clog2(NUM_PHASES);
  localparam int WAITC_W  = $clog2(MAX_WAIT + 1);
  localparam int LAST_IDX = NUM_PHASES - 1;

  seqState_e          state_q, state_d;
  logic [PHASE_W-1:0] phaseIdx_q, phaseIdx_d;
  logic [CNT_W-1:0]   instrCount_q, instrCount_d;
  logic [PHASE_W-1:0] advIdx;
  logic               waitLoad, waitDec, waitZero, waitLast, waitExit;
  logic               atWaitPhase, atLastPhase, waitRequested, finalCycle;
  logic               isBusy;

  wait_counter #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAITC_W)
  ) uWaitCounter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (waitLoad),
    .dec_i      (waitDec),
    .load_val_i (mem_wait),
    .zero_o     (waitZero),
    .last_o     (waitLast)
  );

  assign atWaitPhase   = (phaseIdx_q == PHASE_W'(WAIT_PHASE));
  assign atLastPhase   = (phaseIdx_q == PHASE_W'(LAST_IDX));
  // A zero request clips to zero, so the raw port is enough to decide
  // whether the phase gets stretched.
  assign waitRequested = atWaitPhase && (mem_wait != '0);
  // The zero term only guards against ever sitting in WAIT with nothing left.
  assign waitExit      = waitLast || waitZero;

  // Final cycle of an instruction. When WAIT_PHASE is the last phase, the
  // zero-wait case cannot be known before mem_wait is seen, so only that
  // configuration lets mem_wait reach instr_done.
  assign finalCycle = atLastPhase &&
                      (((state_q == EXEC) && !waitRequested) ||
                       ((state_q == WAIT) && waitExit));

`ifdef PHASE_SKIP_EN
  // Skipped phases are jumped over; a skipped WAIT_PHASE is never entered,
  // so it can never insert wait states.
  always_comb begin
    advIdx = PHASE_W'(nextPhase(int'(phaseIdx_q), LAST_IDX, 32'(skip)));
  end
`else
  logic unusedSkip;
  assign unusedSkip = ^skip;

  // Every phase executes in order.
  always_comb begin
    advIdx = phaseIdx_q + PHASE_W'(1);
  end
`endif

  // Next-state logic. Phase advance and wait handling come first; the
  // final-cycle block then overrides them with the end-of-instruction
  // decision (halt beats run beats idle).
  always_comb begin
    state_d      = state_q;
    phaseIdx_d   = phaseIdx_q;
    instrCount_d = instrCount_q;
    waitLoad     = 1'b0;
    waitDec      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (run || step) begin
          state_d    = EXEC;
          phaseIdx_d = '0;
        end
      end
      EXEC: begin
        if (waitRequested) begin
          waitLoad = 1'b1;
          state_d  = WAIT;
        end else if (!atLastPhase) begin
          phaseIdx_d = advIdx;
        end
      end
      WAIT: begin
        waitDec = 1'b1;
        if (waitExit && !atLastPhase) begin
          state_d    = EXEC;
          phaseIdx_d = advIdx;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (finalCycle) begin
      instrCount_d = instrCount_q + CNT_W'(1);
      phaseIdx_d   = '0;
      if (halt_req) begin
        state_d = HALTED;
      end else if (run) begin
        state_d = EXEC;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // State, phase index and instruction counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      phaseIdx_q   <= '0;
      instrCount_q <= '0;
    end else begin
      state_q      <= state_d;
      phaseIdx_q   <= phaseIdx_d;
      instrCount_q <= instrCount_d;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    isBusy      = (state_q == EXEC) || (state_q == WAIT);
    busy        = isBusy;
    halted      = (state_q == HALTED);
    phase       = '0;
    phase_idx   = '0;
    if (isBusy) begin
      phase     = NUM_PHASES'(1) << phaseIdx_q;
      phase_idx = phaseIdx_q;
    end
    instr_done  = finalCycle;
    instr_count = instrCount_q;
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// ---------------------------------------------------------------------------
// tb_phase_sequencer
// Directed bench for phase_sequencer (NUM_PHASES=5, WAIT_PHASE=1,
// MAX_WAIT=3, CNT_W=16). Each stimulus cycle pushes the hand-computed
// outputs for that cycle into a queue; a monitor on the falling edge pops
// and compares. Honours PHASE_SKIP_EN in the skip section.
// ---------------------------------------------------------------------------
module tb_phase_sequencer;

  localparam int NP  = 5;
  localparam int WP  = 1;
  localparam int MW  = 3;
  localparam int CW  = 16;
  localparam int MWW = $clog2(MW + 1);
  localparam int PW  = $clog2(NP);

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic          step;
  logic          halt_req;
  logic [MWW-1:0] mem_wait;
  logic [NP-1:0] skip;
  logic [NP-1:0] phase;
  logic [PW-1:0] phase_idx;
  logic          instr_done;
  logic          busy;
  logic          halted;
  logic [CW-1:0] instr_count;

  typedef struct {
    logic [NP-1:0] phase;
    logic          done;
    logic          busy;
    logic          halted;
    logic [CW-1:0] count;
    string         label;
  } exp_t;

  exp_t  expQ[$];
  int    compared   = 0;
  int    mismatched = 0;
  string curLabel   = "init";

  phase_sequencer #(
    .NUM_PHASES (NP),
    .WAIT_PHASE (WP),
    .MAX_WAIT   (MW),
    .CNT_W      (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .step        (step),
    .halt_req    (halt_req),
    .mem_wait    (mem_wait),
    .skip        (skip),
    .phase       (phase),
    .phase_idx   (phase_idx),
    .instr_done  (instr_done),
    .busy        (busy),
    .halted      (halted),
    .instr_count (instr_count)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Expected phase index follows from the expected one-hot phase.
  function automatic logic [PW-1:0] idxOf(input logic [NP-1:0] oh);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < NP; i++) begin
      if (oh[i]) r = PW'(i);
    end
    return r;
  endfunction

  task automatic checkOutput(input exp_t e);
    logic [PW-1:0] eIdx;
    eIdx = idxOf(e.phase);
    compared++;
    if (phase !== e.phase || phase_idx !== eIdx || instr_done !== e.done ||
        busy !== e.busy || halted !== e.halted || instr_count !== e.count) begin
      mismatched++;
      $display("[TB] FAIL %s @%0t: got phase=%b idx=%0d done=%b busy=%b halted=%b count=%0d, expected phase=%b idx=%0d done=%b busy=%b halted=%b count=%0d",
               e.label, $time, phase, phase_idx, instr_done, busy, halted, instr_count,
               e.phase, eIdx, e.done, e.busy, e.halted, e.count);
    end
  endtask

  // Monitor: compare whatever expectation is pending on each falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput(e);
    end
  end

  // One cycle: drive inputs just after the rising edge and record the
  // outputs expected at the following falling edge.
  task automatic applyStimulus(input int r, input int ru, input int st, input int hr,
                               input int mw, input int sk, input int ePh,
                               input int eDone, input int eBusy, input int eHalt,
                               input int eCnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst      = (r != 0);
    run      = (ru != 0);
    step     = (st != 0);
    halt_req = (hr != 0);
    mem_wait = MWW'(mw);
    skip     = NP'(sk);
    e.phase  = NP'(ePh);
    e.done   = (eDone != 0);
    e.busy   = (eBusy != 0);
    e.halted = (eHalt != 0);
    e.count  = CW'(eCnt);
    e.label  = curLabel;
    expQ.push_back(e);
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; step = 1'b0; halt_req = 1'b0; mem_wait = '0; skip = '0;

    curLabel = "reset";
    applyStimulus(1,0,0,0,0,0, 0,0,0,0,0);
    applyStimulus(0,0,0,0,0,0, 0,0,0,0,0);
    applyStimulus(0,0,0,0,0,0, 0,0,0,0,0);

    // Three back-to-back instructions; run drops mid-way through the third.
    curLabel = "freerun";
    applyStimulus(0,1,0,0,0,0, 0,0,0,0,0);
    for (int i = 0; i < 3; i++) begin
      for (int p = 0; p < NP; p++) begin
        applyStimulus(0, (i == 2 && p >= 2) ? 0 : 1, 0,0,0,0,
                      1 << p, (p == NP-1) ? 1 : 0, 1, 0, i);
      end
    end
    applyStimulus(0,0,0,0,0,0, 0,0,0,0,3);

    // Single step with two wait states; a second step mid-instruction is dropped.
    curLabel = "step_wait2";
    applyStimulus(0,0,1,0,0,0, 0,0,0,0,3);
    applyStimulus(0,0,1,0,0,0, 5'b00001,0,1,0,3);
    applyStimulus(0,0,0,0,2,0, 5'b00010,0,1,0,3);
    applyStimulus(0,0,0,0,2,0, 5'b00010,0,1,0,3);
    applyStimulus(0,0,0,0,0,0, 5'b00010,0,1,0,3);
    applyStimulus(0,0,0,0,0,0, 5'b00100,0,1,0,3);
    applyStimulus(0,0,0,0,0,0, 5'b01000,0,1,0,3);
    applyStimulus(0,0,0,0,0,0, 5'b10000,1,1,0,3);
    applyStimulus(0,0,0,0,0,0, 0,0,0,0,4);
    applyStimulus(0,0,0,0,0,0, 0,0,0,0,4);

    // Request 7 (all ones on the narrow port): stretch caps at MAX_WAIT.
    curLabel = "max_wait";
    applyStimulus(0,0,1,0,0,0, 0,0,0,0,4);
    applyStimulus(0,0,0,0,0,0, 5'b00001,0,1,0,4);
    applyStimulus(0,0,0,0,7,0, 5'b00010,0,1,0,4);
    applyStimulus(0,0,0,0,0,0, 5'b00010,0,1,0,4);
    applyStimulus(0,0,0,0,0,0, 5'b00010,0,1,0,4);
    applyStimulus(0,0,0,0,0,0, 5'b00010,0,1,0,4);
    applyStimulus(0,0,0,0,0,0, 5'b00100,0,1,0,4);
    applyStimulus(0,0,0,0,0,0, 5'b01000,0,1,0,4);
    applyStimulus(0,0,0,0,0,0, 5'b10000,1,1,0,4);
    applyStimulus(0,0,0,0,0,0, 0,0,0,0,5);

    // halt_req in phase 2 is ignored; in the last phase it latches HALTED.
    curLabel = "halt";
    applyStimulus(0,1,0,0,0,0, 0,0,0,0,5);
    applyStimulus(0,1,0,0,0,0, 5'b00001,0,1,0,5);
    applyStimulus(0,1,0,0,0,0, 5'b00010,0,1,0,5);
    applyStimulus(0,1,0,1,0,0, 5'b00100,0,1,0,5);
    applyStimulus(0,1,0,0,0,0, 5'b01000,0,1,0,5);
    applyStimulus(0,1,0,1,0,0, 5'b10000,1,1,0,5);
    applyStimulus(0,1,1,0,0,0, 0,0,0,1,6);
    applyStimulus(0,1,1,0,0,0, 0,0,0,1,6);
    applyStimulus(0,1,0,0,0,0, 0,0,0,1,6);

    // Reset clears HALTED; a second reset in phase 3 clears outputs at once.
    curLabel = "async_reset";
    applyStimulus(1,1,0,0,0,0, 0,0,0,0,0);
    applyStimulus(0,1,0,0,0,0, 0,0,0,0,0);
    applyStimulus(0,1,0,0,0,0, 5'b00001,0,1,0,0);
    applyStimulus(0,1,0,0,0,0, 5'b00010,0,1,0,0);
    applyStimulus(0,1,0,0,0,0, 5'b00100,0,1,0,0);
    applyStimulus(1,1,0,0,0,0, 0,0,0,0,0);
    applyStimulus(0,1,0,0,0,0, 0,0,0,0,0);
    applyStimulus(0,1,0,0,0,0, 5'b00001,0,1,0,0);
    applyStimulus(0,1,0,0,0,0, 5'b00010,0,1,0,0);
    applyStimulus(0,1,0,0,0,0, 5'b00100,0,1,0,0);
    applyStimulus(0,1,0,0,0,0, 5'b01000,0,1,0,0);
    applyStimulus(0,0,0,0,0,0, 5'b10000,1,1,0,0);
    applyStimulus(0,0,0,0,0,0, 0,0,0,0,1);

    // Skip mask 01011 with a wait request pending on the (skipped) phase 1.
    curLabel = "skip";
    applyStimulus(0,1,0,0,2,5'b01011, 0,0,0,0,1);
`ifdef PHASE_SKIP_EN
    applyStimulus(0,1,0,0,2,5'b01011, 5'b00001,0,1,0,1);
    applyStimulus(0,1,0,0,2,5'b01011, 5'b00100,0,1,0,1);
    applyStimulus(0,1,0,0,2,5'b01011, 5'b10000,1,1,0,1);
    applyStimulus(0,1,0,0,2,5'b01011, 5'b00001,0,1,0,2);
    applyStimulus(0,1,0,0,2,5'b01011, 5'b00100,0,1,0,2);
    applyStimulus(0,0,0,0,2,5'b01011, 5'b10000,1,1,0,2);
    applyStimulus(0,0,0,0,0,0,        0,0,0,0,3);
`else
    applyStimulus(0,1,0,0,2,5'b01011, 5'b00001,0,1,0,1);
    applyStimulus(0,1,0,0,2,5'b01011, 5'b00010,0,1,0,1);
    applyStimulus(0,1,0,0,2,5'b01011, 5'b00010,0,1,0,1);
    applyStimulus(0,1,0,0,2,5'b01011, 5'b00010,0,1,0,1);
    applyStimulus(0,1,0,0,2,5'b01011, 5'b00100,0,1,0,1);
    applyStimulus(0,1,0,0,2,5'b01011, 5'b01000,0,1,0,1);
    applyStimulus(0,0,0,0,2,5'b01011, 5'b10000,1,1,0,1);
    applyStimulus(0,0,0,0,0,0,        0,0,0,0,2);
`endif

    // Let the monitor drain, then make sure nothing was left unchecked.
    @(negedge clk);
    #1;
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: got %0d pending expectations, expected 0", expQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion by %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
Parametrised successor of the fixed five-phase counter and halt/exec gating in the multi-cycle SIMPLE core. It generates the one-hot phase strobes that clock IR/AR/BR/DR/SZCV/MDR/PC. It adds configurable phase count, memory wait-state insertion, single-step versus free-run modes, halt latching, and an instruction counter. It sits between the control decoder, the memory, and the datapath register enables.

Parameters:
NUM_PHASES, 5, number of phases per instruction (min 2)
WAIT_PHASE, 1, index of the phase that may be stretched for memory access (< NUM_PHASES)
MAX_WAIT, 3, maximum extra cycles inserted at WAIT_PHASE (>= 1)
CNT_W, 16, instruction counter width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
run  in  1  level; 1 = free-run consecutive instructions
step  in  1  one-cycle pulse, already debounced; executes one instruction when idle
halt_req  in  1  decoder HLT indication; sampled in last phase only
mem_wait  in  $clog2(MAX_WAIT+1)  extra cycles requested; sampled on first cycle of WAIT_PHASE
skip  in  NUM_PHASES  per-phase skip mask (used only with PHASE_SKIP_EN)
phase  out  NUM_PHASES  one-hot active phase, all-zero when not executing
phase_idx  out  $clog2(NUM_PHASES)  index of active phase, 0 when not executing
instr_done  out  1  high during final cycle of the last phase
busy  out  1  high while an instruction is in progress
halted  out  1  sticky halt flag
instr_count  out  CNT_W  completed-instruction count

Behaviour:
- Reset (async, any time, including mid-instruction): state IDLE; phase=0, phase_idx=0, instr_done=0, busy=0, halted=0, instr_count=0, wait counter=0.
- States: IDLE, EXEC, WAIT, HALTED. All outputs are registered or decoded from registered state only; no input-to-output combinational path.
- IDLE:
  - If run=1 or step=1, the next cycle is EXEC with phase[0]=1, busy=1.
  - If neither is asserted, IDLE holds.
- EXEC:
  - Phase advances by one index per clock.
  - On the first cycle of WAIT_PHASE, the sequencer loads min(mem_wait, MAX_WAIT) into the wait counter.
  - If the loaded value is nonzero, go to WAIT. The phase is held while the counter decrements each cycle. Return to EXEC advancing when the counter reaches 0.
  - Total WAIT_PHASE duration is 1 + min(mem_wait, MAX_WAIT) cycles.
- Last phase (final cycle, after any wait if WAIT_PHASE = NUM_PHASES-1):
  - instr_done=1 and instr_count increments, wrapping from 2^CNT_W-1 to 0.
  - Next state is decided by priority:
    - halt_req=1 goes to HALTED.
    - Otherwise run=1 goes to phase 0 with no bubble.
    - Otherwise IDLE.
- HALTED: phase=0, busy=0, halted=1. run and step are ignored. The only exit is rst.
- run deasserted mid-instruction: the current instruction completes, then IDLE.
- step during EXEC/WAIT is ignored and is not queued.
- step and run both high in IDLE: start. The mode is determined per instruction by run sampled in the last phase.
- halt_req outside the last phase has no effect.
- Exactly one phase bit is set while busy=1.

Optional Feature:
PHASE_SKIP_EN
- Defined: when advancing, any phase whose skip bit is 1 is bypassed and the next unskipped index is taken.
  - skip[0] and skip[NUM_PHASES-1] are ignored; first and last phases always execute.
  - If WAIT_PHASE is skipped, no wait is inserted.
  - The skip mask is sampled at each advance.
- Undefined: the skip port exists but is unused; every phase executes.

Decomposition:
- Package seq_pkg: state enum (IDLE, EXEC, WAIT, HALTED), localparams PH_W=$clog2(NUM_PHASES) and WAIT_W=$clog2(MAX_WAIT+1), and a function computing the next unskipped phase index.
- One sub-module, wait_counter: loadable down-counter with a saturating clip at MAX_WAIT and a zero flag.

Test Plan:
- NUM_PHASES=5, run=1, mem_wait=0 for 3 instructions -> phase sequence 1,2,4,8,16 repeated; instr_done every 5th cycle; instr_count=3; no gap between instructions.
- step pulse in IDLE, mem_wait=2 -> phase[1] held 3 cycles; instr_done at cycle 7 after start; return to IDLE, phase=0; instr_count=1.
- mem_wait=7 with MAX_WAIT=3 -> WAIT_PHASE lasts exactly 4 cycles.
- run=1, halt_req=1 pulsed in phase 2, then held in phase 4 -> first pulse ignored; after the last phase halted=1, phase=0; later run/step produce no activity until rst.
- rst asserted in phase 3 during free-run -> all outputs 0 immediately (async); with run=1 after release, restart at phase[0].
- PHASE_SKIP_EN, skip=5'b01010 -> phases 1,4,16; instr_done every 3 cycles; skip[0]=1 still executes phase 0.
